// File: rtl/cu_pkg.sv
// Shared types and encodings for the ALUSystem control unit.
// The S_WAIT state exists only when SINGLE_STEP_EN is defined.
package cu_pkg;

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_INIT, S_FETCH_L, S_FETCH_H, S_DECODE, S_EXEC, S_HALT, S_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_INIT, S_FETCH_L, S_FETCH_H, S_DECODE, S_EXEC, S_HALT
  } state_t;
`endif

  localparam logic [3:0] OPC_AND = 4'h0, OPC_OR  = 4'h1, OPC_NOT = 4'h2, OPC_ADD = 4'h3;
  localparam logic [3:0] OPC_SUB = 4'h4, OPC_LSR = 4'h5, OPC_LSL = 4'h6, OPC_INC = 4'h7;
  localparam logic [3:0] OPC_DEC = 4'h8, OPC_LDI = 4'h9, OPC_LD  = 4'hA, OPC_ST  = 4'hB;
  localparam logic [3:0] OPC_BRA = 4'hC, OPC_BEQ = 4'hD, OPC_NOP = 4'hE, OPC_HLT = 4'hF;

  localparam logic [1:0] FUN_DEC = 2'b00, FUN_INC = 2'b01, FUN_LOAD = 2'b10, FUN_CLR = 2'b11;

  localparam logic [1:0] MUX_ALU = 2'b00, MUX_MEM = 2'b01, MUX_IMM = 2'b10, MUX_ARFC = 2'b11;
  localparam logic       MUXC_ARF = 1'b0, MUXC_RF = 1'b1;

  localparam logic [3:0] ALU_PASS_A = 4'h0, ALU_NOT = 4'h2, ALU_ADD = 4'h4, ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_AND    = 4'h7, ALU_OR  = 4'h8, ALU_LSL = 4'hB, ALU_LSR = 4'hC;

  localparam logic [1:0] ARF_PC = 2'd0, ARF_AR = 2'd1, ARF_SP = 2'd2;

  typedef struct packed {
    logic [1:0] rf_out_a_sel;
    logic [1:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.rf_reg_sel  = 4'hF;
    c.arf_reg_sel = 3'h7;
    c.mem_cs      = 1'b1;
    return c;
  endfunction

  // Active-low enables: RF bit3 = R1, ARF bit2 = PC.
  function automatic logic [3:0] rf_en(logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

  function automatic logic [2:0] arf_en(logic [1:0] idx);
    return ~(3'b100 >> idx);
  endfunction

  function automatic logic [3:0] alu_func(logic [3:0] opc);
    case (opc)
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      OPC_NOT: return ALU_NOT;
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_LSR: return ALU_LSR;
      OPC_LSL: return ALU_LSL;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational map from {state, T, opcode/fields, z} to the ALUSystem control bundle.
module cu_decoder
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic       t,
  input  logic [7:0] ir_hi,
  input  logic       z,
  output ctrl_t      ctrl
);

  logic [3:0] opc;
  logic [1:0] src, dst;

  assign opc = ir_hi[7:4];
  assign src = ir_hi[3:2];
  assign dst = ir_hi[1:0];

  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      S_INIT: begin
        ctrl.rf_reg_sel  = 4'h0;
        ctrl.rf_fun_sel  = FUN_CLR;
        ctrl.arf_reg_sel = 3'h0;
        ctrl.arf_fun_sel = FUN_CLR;
      end
      S_FETCH_L, S_FETCH_H: begin
        ctrl.arf_out_d_sel = ARF_PC;
        ctrl.mem_cs        = 1'b0;
        ctrl.ir_enable     = 1'b1;
        ctrl.ir_lh         = (state == S_FETCH_H);
        ctrl.ir_fun_sel    = FUN_LOAD;
        ctrl.arf_reg_sel   = arf_en(ARF_PC);
        ctrl.arf_fun_sel   = FUN_INC;
      end
      S_EXEC: begin
        case (opc)
          OPC_AND, OPC_OR, OPC_NOT, OPC_ADD, OPC_SUB, OPC_LSR, OPC_LSL: begin
            ctrl.rf_out_a_sel = dst;
            ctrl.rf_out_b_sel = src;
            ctrl.alu_fun_sel  = alu_func(opc);
            ctrl.mux_c_sel    = MUXC_RF;
            ctrl.mux_a_sel    = MUX_ALU;
            ctrl.rf_reg_sel   = rf_en(dst);
            ctrl.rf_fun_sel   = FUN_LOAD;
          end
          OPC_INC, OPC_DEC: begin
            ctrl.rf_reg_sel = rf_en(dst);
            ctrl.rf_fun_sel = (opc == OPC_INC) ? FUN_INC : FUN_DEC;
          end
          OPC_LDI: begin
            ctrl.mux_a_sel  = MUX_IMM;
            ctrl.rf_reg_sel = rf_en(dst);
            ctrl.rf_fun_sel = FUN_LOAD;
          end
          OPC_LD, OPC_ST: begin
            if (!t) begin
              ctrl.mux_b_sel   = MUX_IMM;
              ctrl.arf_reg_sel = arf_en(ARF_AR);
              ctrl.arf_fun_sel = FUN_LOAD;
            end else if (opc == OPC_LD) begin
              ctrl.arf_out_d_sel = ARF_AR;
              ctrl.mem_cs        = 1'b0;
              ctrl.mux_a_sel     = MUX_MEM;
              ctrl.rf_reg_sel    = rf_en(dst);
              ctrl.rf_fun_sel    = FUN_LOAD;
            end else begin
              ctrl.rf_out_a_sel  = dst;
              ctrl.mux_c_sel     = MUXC_RF;
              ctrl.alu_fun_sel   = ALU_PASS_A;
              ctrl.arf_out_d_sel = ARF_AR;
              ctrl.mem_cs        = 1'b0;
              ctrl.mem_wr        = 1'b1;
            end
          end
          OPC_BRA, OPC_BEQ: begin
            if (opc == OPC_BRA || z) begin
              ctrl.mux_b_sel   = MUX_IMM;
              ctrl.arf_reg_sel = arf_en(ARF_PC);
              ctrl.arf_fun_sel = FUN_LOAD;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for ALUSystem. Optional macro SINGLE_STEP_EN adds the Step
// input and a post-instruction S_WAIT state.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clock,
  input  logic             RESET_N,
`ifdef SINGLE_STEP_EN
  input  logic             Step,
`endif
  input  logic [15:0]      IROut,
  input  logic [3:0]       ALUOutFlag,
  output logic [1:0]       RF_OutASel,
  output logic [1:0]       RF_OutBSel,
  output logic [1:0]       RF_FunSel,
  output logic [3:0]       RF_RegSel,
  output logic [3:0]       ALU_FunSel,
  output logic [1:0]       ARF_OutCSel,
  output logic [1:0]       ARF_OutDSel,
  output logic [1:0]       ARF_FunSel,
  output logic [2:0]       ARF_RegSel,
  output logic             IR_LH,
  output logic             IR_Enable,
  output logic [1:0]       IR_Funsel,
  output logic             Mem_WR,
  output logic             Mem_CS,
  output logic [1:0]       MuxASel,
  output logic [1:0]       MuxBSel,
  output logic             MuxCSel,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);

  state_t           state_q, state_d;
  logic             t_q, t_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       opc;
  logic             last_exec;
  ctrl_t            dec_ctrl, ctrl;
  logic             unused_flags;

  assign opc          = IROut[15:12];
  assign last_exec    = ((opc != OPC_LD) && (opc != OPC_ST)) || t_q;
  assign unused_flags = ^ALUOutFlag[2:0];

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    z_d       = z_q;
    retired_d = retired_q;
    case (state_q)
      S_INIT:    state_d = S_FETCH_L;
      S_FETCH_L: state_d = S_FETCH_H;
      S_FETCH_H: state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
        t_d     = 1'b0;
      end
      S_EXEC: begin
        if (opc <= OPC_LSL) z_d = ALUOutFlag[3];
        if (last_exec) begin
          t_d       = 1'b0;
          retired_d = retired_q + 1'b1;
          if (opc == OPC_HLT) begin
            state_d = S_HALT;
          end else begin
`ifdef SINGLE_STEP_EN
            state_d = S_WAIT;
`else
            state_d = S_FETCH_L;
`endif
          end
        end else begin
          t_d = 1'b1;
        end
      end
`ifdef SINGLE_STEP_EN
      S_WAIT:    if (Step) state_d = S_FETCH_L;
`endif
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_INIT;
      t_q       <= 1'b0;
      z_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      z_q       <= z_d;
      retired_q <= retired_d;
    end
  end

  cu_decoder u_decoder (
    .state (state_q),
    .t     (t_q),
    .ir_hi (IROut[15:8]),
    .z     (z_q),
    .ctrl  (dec_ctrl)
  );

  // While reset is held S_INIT must not clear anything; the clear happens after release.
  assign ctrl = RESET_N ? dec_ctrl : ctrl_idle();

  assign RF_OutASel  = ctrl.rf_out_a_sel;
  assign RF_OutBSel  = ctrl.rf_out_b_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RegSel   = ctrl.rf_reg_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutCSel = ctrl.arf_out_c_sel;
  assign ARF_OutDSel = ctrl.arf_out_d_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_fun_sel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign Halted      = (state_q == S_HALT);
  assign Retired     = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench: behavioural ALUSystem datapath driven by control_unit, checked against an ISA interpreter.
module tb_control_unit;
  import cu_pkg::*;

  logic        Clock = 1'b0;
  logic        RESET_N = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        Step = 1'b1;
`endif
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;
  logic [1:0]  IR_Funsel, MuxASel, MuxBSel;
  logic [15:0] Retired;

  always #5 Clock = ~Clock;

  control_unit #(.CNT_W(16)) dut (
    .Clock       (Clock),
    .RESET_N     (RESET_N),
`ifdef SINGLE_STEP_EN
    .Step        (Step),
`endif
    .IROut       (IROut),
    .ALUOutFlag  (ALUOutFlag),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .RF_FunSel   (RF_FunSel),
    .RF_RegSel   (RF_RegSel),
    .ALU_FunSel  (ALU_FunSel),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RegSel  (ARF_RegSel),
    .IR_LH       (IR_LH),
    .IR_Enable   (IR_Enable),
    .IR_Funsel   (IR_Funsel),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .Halted      (Halted),
    .Retired     (Retired)
  );

  // ---------------- behavioural ALUSystem datapath ----------------
  logic [7:0]  rf [4];
  logic [7:0]  arf [3];
  logic [15:0] ir = 16'h0000;
  logic [7:0]  mem [256];
  logic [7:0]  init_mem [256];
  logic        load_mem = 1'b0;
  logic [7:0]  out_a, out_b, arf_c, arf_d, mem_out, alu_a, alu_out, mux_a, mux_b;
  logic [3:0]  rf_we;
  logic [2:0]  arf_we;

  assign rf_we  = ~{RF_RegSel[0], RF_RegSel[1], RF_RegSel[2], RF_RegSel[3]};
  assign arf_we = ~{ARF_RegSel[0], ARF_RegSel[1], ARF_RegSel[2]};
  assign IROut      = ir;
  assign ALUOutFlag = {alu_out == 8'h00, 1'b0, alu_out[7], 1'b0};

  always_comb begin
    out_a = rf[RF_OutASel];
    out_b = rf[RF_OutBSel];
    case (ARF_OutCSel)
      2'd0: arf_c = arf[0];
      2'd1: arf_c = arf[1];
      2'd2: arf_c = arf[2];
      default: arf_c = 8'h00;
    endcase
    case (ARF_OutDSel)
      2'd0: arf_d = arf[0];
      2'd1: arf_d = arf[1];
      2'd2: arf_d = arf[2];
      default: arf_d = 8'h00;
    endcase
    mem_out = mem[arf_d];
    alu_a   = MuxCSel ? out_a : arf_c;
    case (ALU_FunSel)
      ALU_NOT: alu_out = ~alu_a;
      ALU_ADD: alu_out = alu_a + out_b;
      ALU_SUB: alu_out = alu_a - out_b;
      ALU_AND: alu_out = alu_a & out_b;
      ALU_OR:  alu_out = alu_a | out_b;
      ALU_LSL: alu_out = alu_a << 1;
      ALU_LSR: alu_out = alu_a >> 1;
      default: alu_out = alu_a;
    endcase
    case (MuxASel)
      2'b00: mux_a = alu_out;
      2'b01: mux_a = mem_out;
      2'b10: mux_a = ir[7:0];
      default: mux_a = arf_c;
    endcase
    case (MuxBSel)
      2'b00: mux_b = alu_out;
      2'b01: mux_b = mem_out;
      2'b10: mux_b = ir[7:0];
      default: mux_b = arf_c;
    endcase
  end

  always @(posedge Clock) begin
    if (load_mem) mem <= init_mem;
    else if (!Mem_CS && Mem_WR) mem[arf_d] <= alu_out;
    for (int i = 0; i < 4; i++)
      if (rf_we[i])
        case (RF_FunSel)
          2'b00: rf[i] <= rf[i] - 8'd1;
          2'b01: rf[i] <= rf[i] + 8'd1;
          2'b10: rf[i] <= mux_a;
          default: rf[i] <= 8'h00;
        endcase
    for (int i = 0; i < 3; i++)
      if (arf_we[i])
        case (ARF_FunSel)
          2'b00: arf[i] <= arf[i] - 8'd1;
          2'b01: arf[i] <= arf[i] + 8'd1;
          2'b10: arf[i] <= mux_b;
          default: arf[i] <= 8'h00;
        endcase
    if (IR_Enable && IR_Funsel == 2'b10) begin
      if (IR_LH) ir[15:8] <= mem_out;
      else       ir[7:0]  <= mem_out;
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [7:0] exp_rf [4];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_pc, exp_ar;
  int         exp_retired, exp_cycles;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic model_run();
    logic [7:0]  pc, pc1, a, res;
    logic [3:0]  opc;
    logic [1:0]  s, d;
    logic [15:0] ins;
    logic        z, halt;
    int          n;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_mem[i];
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    pc = 8'h00; z = 1'b0; halt = 1'b0; n = 0;
    exp_ar = 8'h00; exp_retired = 0; exp_cycles = 1;
    while (!halt && n < 1000) begin
      pc1 = pc + 8'd1;
      ins = {exp_mem[pc1], exp_mem[pc]};
      pc  = pc + 8'd2;
      n++;
      opc = ins[15:12]; s = ins[11:10]; d = ins[9:8]; a = ins[7:0];
      exp_cycles += (opc == 4'hA || opc == 4'hB) ? 5 : 4;
      exp_retired++;
      if (opc <= 4'h6) begin
        case (opc)
          4'h0: res = exp_rf[d] & exp_rf[s];
          4'h1: res = exp_rf[d] | exp_rf[s];
          4'h2: res = ~exp_rf[d];
          4'h3: res = exp_rf[d] + exp_rf[s];
          4'h4: res = exp_rf[d] - exp_rf[s];
          4'h5: res = exp_rf[d] >> 1;
          default: res = exp_rf[d] << 1;
        endcase
        exp_rf[d] = res;
        z = (res == 8'h00);
      end else begin
        case (opc)
          4'h7: exp_rf[d] = exp_rf[d] + 8'd1;
          4'h8: exp_rf[d] = exp_rf[d] - 8'd1;
          4'h9: exp_rf[d] = a;
          4'hA: begin exp_ar = a; exp_rf[d] = exp_mem[a]; end
          4'hB: begin exp_ar = a; exp_mem[a] = exp_rf[d]; end
          4'hC: pc = a;
          4'hD: if (z) pc = a;
          4'hF: halt = 1'b1;
          default: ;
        endcase
      end
    end
    exp_pc = pc;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] enc(logic [3:0] o, logic [1:0] s, logic [1:0] d, logic [7:0] a);
    return {o, s, d, a};
  endfunction

  task automatic place(input int addr, input logic [15:0] ins);
    init_mem[addr]     = ins[7:0];
    init_mem[addr + 1] = ins[15:8];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
  endtask

  task automatic run_prog(input string tag);
    int cycles, diffs;
    RESET_N  = 1'b0;
    load_mem = 1'b1;
    @(posedge Clock);
    #1 load_mem = 1'b0;
    model_run();
    @(negedge Clock);
    RESET_N = 1'b1;
    cycles = 0;
    while (Halted !== 1'b1 && cycles < exp_cycles * 4 + 100) begin
      @(posedge Clock);
      #1 cycles++;
    end
    check({tag, ".halted"}, 32'(Halted), 32'd1);
`ifndef SINGLE_STEP_EN
    check({tag, ".cycles"}, cycles, exp_cycles);
`endif
    for (int i = 0; i < 4; i++) check($sformatf("%s.R%0d", tag, i + 1), 32'(rf[i]), 32'(exp_rf[i]));
    check({tag, ".pc"}, 32'(arf[0]), 32'(exp_pc));
    check({tag, ".ar"}, 32'(arf[1]), 32'(exp_ar));
    check({tag, ".retired"}, 32'(Retired), exp_retired);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
    check({tag, ".mem_diffs"}, diffs, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] o;
    logic [7:0] imm;

    // Reset state while RESET_N is held low.
    #1;
    check("rst.halted", 32'(Halted), 32'd0);
    check("rst.retired", 32'(Retired), 32'd0);
    check("rst.rf_regsel", 32'(RF_RegSel), 32'hF);
    check("rst.arf_regsel", 32'(ARF_RegSel), 32'h7);
    check("rst.mem_cs", 32'(Mem_CS), 32'd1);
    check("rst.mem_wr", 32'(Mem_WR), 32'd0);
    check("rst.ir_en", 32'(IR_Enable), 32'd0);

    // Single HLT at address 0.
    clear_mem();
    init_mem[1] = 8'hF0;
    run_prog("hlt");
    check("hlt.ir", 32'(ir), 32'hF000);
    check("hlt.retired_abs", 32'(Retired), 32'd1);

    // LDI R1,5; LDI R2,3; ADD R1<-R1+R2; HLT
    clear_mem();
    place(0, enc(OPC_LDI, 2'd0, 2'd0, 8'h05));
    place(2, enc(OPC_LDI, 2'd0, 2'd1, 8'h03));
    place(4, enc(OPC_ADD, 2'd1, 2'd0, 8'h00));
    place(6, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("add");
    check("add.R1_abs", 32'(rf[0]), 32'h08);
    check("add.retired_abs", 32'(Retired), 32'd4);

    // LDI R3,7; ST R3,[40]; LD R4,[40]; HLT
    clear_mem();
    place(0, enc(OPC_LDI, 2'd0, 2'd2, 8'h07));
    place(2, enc(OPC_ST,  2'd0, 2'd2, 8'h40));
    place(4, enc(OPC_LD,  2'd0, 2'd3, 8'h40));
    place(6, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("ldst");
    check("ldst.mem40_abs", 32'(mem[8'h40]), 32'h07);
    check("ldst.R4_abs", 32'(rf[3]), 32'h07);

    // Zero result -> BEQ taken.
    clear_mem();
    place(0, enc(OPC_LDI, 2'd0, 2'd0, 8'h05));
    place(2, enc(OPC_SUB, 2'd0, 2'd0, 8'h00));
    place(4, enc(OPC_BEQ, 2'd0, 2'd0, 8'h20));
    place(6, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    place(8'h20, enc(OPC_LDI, 2'd0, 2'd1, 8'hAA));
    place(8'h22, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("beq_t");
    check("beq_t.pc_abs", 32'(arf[0]), 32'h24);

    // Non-zero result -> BEQ falls through.
    place(2, enc(OPC_LDI, 2'd0, 2'd1, 8'h03));
    place(4, enc(OPC_SUB, 2'd1, 2'd0, 8'h00));
    place(6, enc(OPC_BEQ, 2'd0, 2'd0, 8'h20));
    place(8, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("beq_nt");
    check("beq_nt.pc_abs", 32'(arf[0]), 32'h0A);

    // BEQ straight after reset sees z=0.
    clear_mem();
    place(0, enc(OPC_BEQ, 2'd0, 2'd0, 8'h20));
    place(2, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    place(8'h20, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("beq_rst");

    // PC wrap FF->00, and z survives a non-flag instruction.
    clear_mem();
    place(0, enc(OPC_BEQ, 2'd0, 2'd0, 8'h20));
    place(2, enc(OPC_SUB, 2'd1, 2'd1, 8'h00));
    place(4, enc(OPC_BRA, 2'd0, 2'd0, 8'hFE));
    place(8'hFE, enc(OPC_LDI, 2'd0, 2'd2, 8'h33));
    place(8'h20, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    run_prog("wrap");
    check("wrap.pc_abs", 32'(arf[0]), 32'h22);

    // Reset asserted during the write cycle of ST.
    clear_mem();
    place(0, enc(OPC_LDI, 2'd0, 2'd2, 8'h07));
    place(2, enc(OPC_ST,  2'd0, 2'd2, 8'h40));
    place(4, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
    init_mem[8'h40] = 8'h55;
    RESET_N = 1'b0; load_mem = 1'b1;
    @(posedge Clock);
    #1 load_mem = 1'b0;
    @(negedge Clock);
    RESET_N = 1'b1;
    n = 0;
    while (Mem_WR !== 1'b1 && n < 40) begin
      @(posedge Clock);
      #1 n++;
    end
    check("rstst.reached_write", 32'(Mem_WR), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("rstst.mem_cs", 32'(Mem_CS), 32'd1);
    check("rstst.mem_wr", 32'(Mem_WR), 32'd0);
    check("rstst.rf_regsel", 32'(RF_RegSel), 32'hF);
    check("rstst.arf_regsel", 32'(ARF_RegSel), 32'h7);
    @(posedge Clock);
    #1;
    check("rstst.mem40_kept", 32'(mem[8'h40]), 32'h55);
    check("rstst.retired", 32'(Retired), 32'd0);
    @(negedge Clock);
    RESET_N = 1'b1;
    @(posedge Clock);
    #1;
    check("rstst.pc_cleared", 32'(arf[0]), 32'h00);
    n = 0;
    while (Halted !== 1'b1 && n < 200) begin
      @(posedge Clock);
      #1 n++;
    end
    check("rstst.halted", 32'(Halted), 32'd1);
    check("rstst.mem40", 32'(mem[8'h40]), 32'h07);
    check("rstst.retired_end", 32'(Retired), 32'd3);

    // Random programs: forward-only branches, data accesses in 0x80..0xFF.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
      for (int k = 0; k < 12; k++) begin
        o   = 4'($urandom_range(0, 14));
        imm = 8'($urandom);
        if (o == OPC_LD || o == OPC_ST) imm = 8'($urandom_range(128, 255));
        if (o == OPC_BRA || o == OPC_BEQ) imm = 8'(2 * $urandom_range(k + 1, 12));
        place(2 * k, enc(o, 2'($urandom), 2'($urandom), imm));
      end
      place(24, enc(OPC_HLT, 2'd0, 2'd0, 8'h00));
      run_prog($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
